// File: rtl/uart_buffered.sv
// Buffered UART: 16x oversampling divisor, register-based TX/RX FIFOs, sticky RX error flags.
// Optional parity bit in both directions when UART_PARITY_EN is defined (polarity from PARITY_ODD).
module uart_buffered #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned L  = AW + 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 div_wr,
    input  logic [15:0]          div_in,
    input  logic [DATA_BITS-1:0] txd_data,
    input  logic                 txd_wr_en,
    output logic                 txd_full,
    output logic                 txd_empty,
    output logic [L-1:0]         txd_level,
    output logic [DATA_BITS-1:0] rxd_data,
    input  logic                 rxd_rd_en,
    output logic                 rxd_empty,
    output logic                 rxd_full,
    output logic [L-1:0]         rxd_level,
    input  logic                 err_clr,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 uart_rx,
    output logic                 uart_tx
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : gen_param_check
        $error("uart_buffered: illegal parameter value");
    end

    localparam logic [15:0] DivReset = 16'((CLK_FREQ / BAUD) / 16);

`ifdef UART_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // Oversample tick generator
    logic [15:0] div_q, div_cnt_q, div_eff;
    logic        tick;

    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = (div_cnt_q == div_eff - 16'd1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q     <= DivReset;
            div_cnt_q <= 16'd0;
        end else if (div_wr) begin
            div_q     <= div_in;
            div_cnt_q <= 16'd0;
        end else if (tick) begin
            div_cnt_q <= 16'd0;
        end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
        end
    end

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [L-1:0]         tx_wptr_q, tx_rptr_q;
    logic                 tx_push, tx_pop, tx_fifo_empty;
    logic [DATA_BITS-1:0] tx_head;

    assign txd_level     = tx_wptr_q - tx_rptr_q;
    assign txd_full      = (txd_level == L'(FIFO_DEPTH));
    assign tx_fifo_empty = (txd_level == '0);
    assign tx_push       = txd_wr_en && !txd_full;
    assign tx_head       = tx_mem[tx_rptr_q[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= txd_data;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + L'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + L'(1);
        end
    end

    // TX FSM: all state changes land on a tick so every bit is exactly 16 ticks wide
    state_e               tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tick) begin
            tx_tick_d = tx_tick_q + 4'd1;
            unique case (tx_state_q)
                StIdle: begin
                    tx_tick_d = 4'd0;
                    tx_pop    = !tx_fifo_empty;
                end
                StStart: begin
                    if (tx_tick_q == 4'd15) begin
                        tx_state_d = StData;
                        tx_bit_d   = 3'd0;
                    end
                end
                StData: begin
                    if (tx_tick_q == 4'd15) begin
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_d = StParity;
`else
                            tx_state_d = StStop;
`endif
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (tx_tick_q == 4'd15) tx_state_d = StStop;
                end
`endif
                StStop: begin
                    if (tx_tick_q == 4'd15) begin
                        tx_state_d = StIdle;
                        tx_pop     = !tx_fifo_empty;
                    end
                end
                default: tx_state_d = StIdle;
            endcase
        end
        if (tx_pop) begin
            tx_state_d = StStart;
            tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_head) ^ ParOdd;
`endif
        end

        tx_d = 1'b1;
        case (tx_state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            StParity: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state_q <= StIdle;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign uart_tx   = tx_q;
    assign txd_empty = tx_fifo_empty && (tx_state_q == StIdle);

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [L-1:0]         rx_wptr_q, rx_rptr_q;
    logic                 rx_push, rx_pop;

    assign rxd_level = rx_wptr_q - rx_rptr_q;
    assign rxd_full  = (rxd_level == L'(FIFO_DEPTH));
    assign rxd_empty = (rxd_level == '0);
    assign rx_pop    = rxd_rd_en && !rxd_empty;
    assign rxd_data  = rx_mem[rx_rptr_q[AW-1:0]];

    // RX FSM; rx_push is only raised when the FIFO has room
    state_e               rx_state_q, rx_state_d;
    logic [3:0]           rx_tick_q, rx_tick_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_mid, rx_end, set_overrun, set_frame;
`ifdef UART_PARITY_EN
    logic                 set_parity;
`endif

    always_ff @(posedge sys_clk) begin
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + L'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + L'(1);
        end
    end

    assign rx_mid = tick && (rx_tick_q == 4'd7);
    assign rx_end = tick && (rx_tick_q == 4'd15);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = tick ? rx_tick_q + 4'd1 : rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        set_overrun = 1'b0;
        set_frame   = 1'b0;
`ifdef UART_PARITY_EN
        set_parity  = 1'b0;
`endif
        unique case (rx_state_q)
            StIdle: begin
                rx_tick_d = 4'd0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = StStart;
            end
            StStart: begin
                if (rx_mid && rx_sync_q) begin
                    rx_state_d = StIdle;
                end else if (rx_end) begin
                    rx_state_d = StData;
                    rx_bit_d   = 3'd0;
                end
            end
            StData: begin
                if (rx_mid) rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_end) begin
                    if (rx_bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_d = StParity;
`else
                        rx_state_d = StStop;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (rx_mid && (rx_sync_q != ((^rx_shift_q) ^ ParOdd))) set_parity = 1'b1;
                if (rx_end) rx_state_d = StStop;
            end
`endif
            StStop: begin
                // Return to idle at mid-stop so a back-to-back start edge is not missed
                if (rx_mid) begin
                    rx_state_d = StIdle;
                    if (!rx_sync_q)    set_frame   = 1'b1;
                    else if (rxd_full) set_overrun = 1'b1;
                    else               rx_push     = 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state_q   <= StIdle;
            rx_tick_q    <= 4'd0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_overrun   <= set_overrun | (rx_overrun & ~err_clr);
            rx_frame_err <= set_frame | (rx_frame_err & ~err_clr);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) rx_parity_err <= 1'b0;
        else         rx_parity_err <= set_parity | (rx_parity_err & ~err_clr);
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, character width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two 2..256, entries per FIFO.
REQ-005 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; used only with UART_PARITY_EN.
REQ-006 SHALL have ports, one per line; L = log2(FIFO_DEPTH)+1:
 sys_clk  in  1  clock
 sys_rst  in  1  reset, asynchronous, active-high
 div_wr  in  1  load div_in into divisor register
 div_in  in  16  oversample divisor, clocks per 1/16 bit
 txd_data  in  DATA_BITS  TX write data
 txd_wr_en  in  1  push txd_data into TX FIFO
 txd_full  out  1  TX FIFO full
 txd_empty  out  1  TX FIFO empty and shifter idle
 txd_level  out  L  TX FIFO occupancy
 rxd_data  out  DATA_BITS  RX FIFO head, first-word-fall-through
 rxd_rd_en  in  1  pop RX FIFO
 rxd_empty  out  1  RX FIFO empty
 rxd_full  out  1  RX FIFO full
 rxd_level  out  L  RX FIFO occupancy
 err_clr  in  1  clear sticky error flags
 rx_overrun  out  1  sticky, character lost to full RX FIFO
 rx_frame_err  out  1  sticky, stop bit sampled low
 rx_parity_err  out  1  sticky, parity mismatch
 uart_rx  in  1  serial input, asynchronous
 uart_tx  out  1  serial output

Function
REQ-007 SHALL hold 16-bit divisor register, reset CLK_FREQ/BAUD/16; div_wr loads div_in next cycle; value 0 treated as 1.
REQ-008 SHALL generate one-cycle oversample tick each time the divisor counter reaches divisor-1, then wrap to 0; div_wr restarts counter at 0.
REQ-009 SHALL implement two FIFOs internally in registers, no vendor IP; pointers wrap modulo FIFO_DEPTH; level = write count minus read count.
REQ-010 SHALL ignore write when full and read when empty, with no pointer or level change.
REQ-011 SHALL, on simultaneous read and write with FIFO neither full nor empty, perform both, level unchanged; when full, perform only the read; when empty, perform only the write.
REQ-012 SHALL present rxd_data as the head entry whenever rxd_empty=0; value undefined when empty.
REQ-013 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; each state lasts 16 ticks.
REQ-014 TX SHALL leave IDLE when FIFO non-empty, popping one entry same cycle; sends start 0, DATA_BITS LSB first, optional parity, one stop 1; returns to IDLE, and back-to-back characters have no extra idle gap.
REQ-015 uart_tx SHALL be registered, 1 in IDLE and reset.
REQ-016 RX SHALL synchronise uart_rx through two flops; falling edge in IDLE starts a start bit; low re-checked at tick 8, high aborts to IDLE silently.
REQ-017 RX SHALL sample each data, parity and stop bit at tick 8 of its bit period.
REQ-018 On stop sample RX SHALL: if stop=0 set rx_frame_err and discard; else if RX FIFO full set rx_overrun and discard; else push character; then IDLE.
REQ-019 Parity mismatch SHALL set rx_parity_err; character still pushed if stop valid.
REQ-020 err_clr SHALL clear all three flags; a set event in the same cycle SHALL win.
REQ-021 txd_empty SHALL be 1 only when TX FIFO empty and TX FSM in IDLE.

Reset
REQ-022 sys_rst SHALL asynchronously force: FIFOs empty, levels 0, txd_empty=1, rxd_empty=1, full flags 0, error flags 0, both FSMs IDLE, uart_tx=1, divisor to reset value, synchroniser flops 1.
REQ-023 Reset mid-character SHALL abort without pushing or popping further entries; FIFO contents are not preserved.

Configuration
REQ-024 Macro UART_PARITY_EN defined SHALL enable the PARITY state in TX and RX and the parity check, polarity per PARITY_ODD.
REQ-025 Without UART_PARITY_EN, PARITY state SHALL be absent, frame = start + DATA_BITS + stop, and rx_parity_err SHALL be constant 0.

Verification
REQ-026 Defaults, push 0xA5 -> uart_tx low 864 clocks, then bits 1,0,1,0,0,1,0,1 at 864 each, then high; txd_empty=1 after stop.
REQ-027 Push 17 bytes into TX while idle -> 17th write dropped, txd_full=1 at level 16, exactly 16 characters transmitted.
REQ-028 Loop uart_tx to uart_rx, div_wr div_in=27, send 0x00, 0xFF, 0x3C -> RX FIFO holds same 3 values in order, rxd_level=3.
REQ-029 Drive 17 characters into RX with no reads -> rxd_full=1, rx_overrun=1, first 16 retained; err_clr -> rx_overrun=0.
REQ-030 Drive character with stop bit 0 -> rx_frame_err=1, rxd_level unchanged; 0.4-bit low glitch -> no character, no error.
REQ-031 UART_PARITY_EN, PARITY_ODD=0, send 0x01 with parity 0 -> rx_parity_err=1, 0x01 pushed; reset asserted mid-TX -> uart_tx=1 immediately, txd_level=0.
